// File: rtl/ascon_pkg.sv
// Shared types and helpers for the ASCON AEAD core: state struct, FSM encoding,
// IV construction, round constants, S-box table and rotation.
package ascon_pkg;

   typedef struct packed {
      logic [63:0] x0;
      logic [63:0] x1;
      logic [63:0] x2;
      logic [63:0] x3;
      logic [63:0] x4;
   } state_t;

   typedef enum logic [2:0] {
      IDLE,
      INIT,
      AD_WAIT,
      AD_PERM,
      PT_WAIT,
      PT_PERM,
      FINAL
   } fsm_t;

   // Indexed by the bit column {x0,x1,x2,x3,x4}, x0 being the MSB.
   localparam logic [0:31][4:0] SBOX = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   function automatic logic [63:0] iv(input int ra, input int rb);
      return {8'h80, 8'h40, 8'(ra), 8'(rb), 32'h0};
   endfunction

   // With j = 12 - n + i held in 4 bits, (15 - j) is simply ~j.
   function automatic logic [7:0] round_const(input logic [3:0] n, input logic [3:0] i);
      logic [3:0] j;
      j = 4'd12 - n + i;
      return {~j, j};
   endfunction

   function automatic logic [4:0] sbox(input logic [4:0] v);
      return SBOX[v];
   endfunction

   function automatic logic [63:0] ror(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational ASCON round: constant addition into x2, 5-bit S-box across
// all 64 bit columns, then the per-word linear diffusion layer.
module ascon_round
   import ascon_pkg::*;
(
   input  state_t     s,
   input  logic [7:0] c,
   output state_t     y
);

   state_t a;
   state_t b;

   always_comb begin
      a    = s;
      a.x2 = s.x2 ^ {56'd0, c};
      b    = a;
      for (int i = 0; i < 64; i++) begin
         {b.x0[i], b.x1[i], b.x2[i], b.x3[i], b.x4[i]} =
            sbox({a.x0[i], a.x1[i], a.x2[i], a.x3[i], a.x4[i]});
      end
   end

   assign y = '{
      x0: b.x0 ^ ror(b.x0, 19) ^ ror(b.x0, 28),
      x1: b.x1 ^ ror(b.x1, 61) ^ ror(b.x1, 39),
      x2: b.x2 ^ ror(b.x2,  1) ^ ror(b.x2,  6),
      x3: b.x3 ^ ror(b.x3, 10) ^ ror(b.x3, 17),
      x4: b.x4 ^ ror(b.x4,  7) ^ ror(b.x4, 41)
   };

endmodule

// File: rtl/ascon_aead_core.sv
// ASCON AEAD core, 64-bit rate, one round per cycle, variable AD/PT block counts.
// Define ASCON_DECRYPT_EN to add the decryption path and tag verification.
module ascon_aead_core
   import ascon_pkg::*;
#(
   parameter int MAX_AD_BLOCKS = 4,
   parameter int MAX_PT_BLOCKS = 8,
   parameter int ROUNDS_A      = 12,
   parameter int ROUNDS_B      = 6
) (
   input  logic                               clock_i,
   input  logic                               reset_i,
   input  logic                               start_i,
   input  logic [127:0]                       key_i,
   input  logic [127:0]                       nonce_i,
   input  logic [$clog2(MAX_AD_BLOCKS+1)-1:0] nb_ad_i,
   input  logic [$clog2(MAX_PT_BLOCKS+1)-1:0] nb_pt_i,
   input  logic [63:0]                        data_i,
   input  logic                               data_valid_i,
   output logic                               ready_o,
   output logic                               busy_o,
   output logic [63:0]                        cipher_o,
   output logic                               cipher_valid_o,
   output logic [127:0]                       tag_o,
   output logic                               end_o,
`ifdef ASCON_DECRYPT_EN
   input  logic                               decrypt_i,
   input  logic [127:0]                       tag_i,
   output logic                               tag_ok_o,
`endif
   output logic                               err_o
);

   localparam int AW = $clog2(MAX_AD_BLOCKS + 1);
   localparam int PW = $clog2(MAX_PT_BLOCKS + 1);

   fsm_t          state;
   state_t        s;
   state_t        s_rnd;
   logic [127:0]  key_q;
   logic [AW-1:0] nb_ad_q;
   logic [AW-1:0] ad_cnt;
   logic [PW-1:0] nb_pt_q;
   logic [PW-1:0] pt_cnt;
   logic [3:0]    rnd;
   logic [3:0]    n_rounds;
   logic [7:0]    rc;
   logic          last_rnd;
   logic          last_pt;
   logic          start_ok;
   logic [63:0]   x0_abs;
   logic [127:0]  tag_calc;

   assign n_rounds = (state == INIT || state == FINAL) ? 4'(ROUNDS_A) : 4'(ROUNDS_B);
   assign last_rnd = (rnd == n_rounds - 4'd1);
   assign rc       = round_const(n_rounds, rnd);
   assign ready_o  = (state == AD_WAIT) || (state == PT_WAIT);
   assign busy_o   = (state != IDLE);
   assign last_pt  = (pt_cnt == nb_pt_q - PW'(1));
   assign start_ok = (nb_pt_i != '0) && (nb_pt_i <= PW'(MAX_PT_BLOCKS))
                     && (nb_ad_i <= AW'(MAX_AD_BLOCKS));
   assign tag_calc = {s_rnd.x3 ^ key_q[127:64], s_rnd.x4 ^ key_q[63:0]};

`ifdef ASCON_DECRYPT_EN
   logic         decrypt_q;
   logic [127:0] tag_ref_q;
   // When decrypting, the ciphertext itself becomes the new rate word.
   assign x0_abs = decrypt_q ? data_i : (s.x0 ^ data_i);
`else
   assign x0_abs = s.x0 ^ data_i;
`endif

   ascon_round u_round (
      .s (s),
      .c (rc),
      .y (s_rnd)
   );

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state          <= IDLE;
         s              <= '0;
         key_q          <= '0;
         nb_ad_q        <= '0;
         nb_pt_q        <= '0;
         ad_cnt         <= '0;
         pt_cnt         <= '0;
         rnd            <= '0;
         cipher_o       <= '0;
         cipher_valid_o <= 1'b0;
         tag_o          <= '0;
         end_o          <= 1'b0;
         err_o          <= 1'b0;
`ifdef ASCON_DECRYPT_EN
         decrypt_q      <= 1'b0;
         tag_ref_q      <= '0;
         tag_ok_o       <= 1'b0;
`endif
      end else begin
         cipher_valid_o <= 1'b0;
         end_o          <= 1'b0;
         err_o          <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (start_ok) begin
                     s <= '{x0: iv(ROUNDS_A, ROUNDS_B), x1: key_i[127:64], x2: key_i[63:0],
                            x3: nonce_i[127:64], x4: nonce_i[63:0]};
                     key_q   <= key_i;
                     nb_ad_q <= nb_ad_i;
                     nb_pt_q <= nb_pt_i;
                     ad_cnt  <= '0;
                     pt_cnt  <= '0;
                     rnd     <= '0;
`ifdef ASCON_DECRYPT_EN
                     decrypt_q <= decrypt_i;
                     tag_ref_q <= tag_i;
`endif
                     state   <= INIT;
                  end else begin
                     err_o <= 1'b1;
                  end
               end
            end
            INIT: begin
               s   <= s_rnd;
               rnd <= rnd + 4'd1;
               if (last_rnd) begin
                  rnd   <= '0;
                  s.x3  <= s_rnd.x3 ^ key_q[127:64];
                  s.x4  <= s_rnd.x4 ^ key_q[63:0] ^ {63'd0, nb_ad_q == '0};
                  state <= (nb_ad_q == '0) ? PT_WAIT : AD_WAIT;
               end
            end
            AD_WAIT: begin
               if (data_valid_i) begin
                  s.x0 <= s.x0 ^ data_i;
                  if (ad_cnt < nb_ad_q) ad_cnt <= ad_cnt + AW'(1);
                  state <= AD_PERM;
               end
            end
            AD_PERM: begin
               s   <= s_rnd;
               rnd <= rnd + 4'd1;
               if (last_rnd) begin
                  rnd <= '0;
                  if (ad_cnt == nb_ad_q) begin
                     s.x4  <= s_rnd.x4 ^ 64'd1;
                     state <= PT_WAIT;
                  end else begin
                     state <= AD_WAIT;
                  end
               end
            end
            PT_WAIT: begin
               if (data_valid_i) begin
                  s.x0           <= x0_abs;
                  cipher_o       <= s.x0 ^ data_i;
                  cipher_valid_o <= 1'b1;
                  if (last_pt) begin
                     s.x1  <= s.x1 ^ key_q[127:64];
                     s.x2  <= s.x2 ^ key_q[63:0];
                     state <= FINAL;
                  end else begin
                     pt_cnt <= pt_cnt + PW'(1);
                     state  <= PT_PERM;
                  end
               end
            end
            PT_PERM: begin
               s   <= s_rnd;
               rnd <= rnd + 4'd1;
               if (last_rnd) begin
                  rnd   <= '0;
                  state <= PT_WAIT;
               end
            end
            FINAL: begin
               s   <= s_rnd;
               rnd <= rnd + 4'd1;
               if (last_rnd) begin
                  rnd   <= '0;
                  tag_o <= tag_calc;
                  end_o <= 1'b1;
`ifdef ASCON_DECRYPT_EN
                  tag_ok_o <= (tag_calc == tag_ref_q);
`endif
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ascon_aead_core.sv
// Randomised self-checking bench for ascon_aead_core against a bitsliced
// ASCON reference model. Covers ASCON_DECRYPT_EN when that macro is defined.
module tb_ascon_aead_core;

   localparam int RA    = 12;
   localparam int RB    = 6;
   localparam int MAXAD = 4;
   localparam int MAXPT = 8;

   typedef logic [4:0][63:0] mstate_t;

   logic         clock_i = 1'b0;
   logic         reset_i;
   logic         start_i;
   logic [127:0] key_i;
   logic [127:0] nonce_i;
   logic [2:0]   nb_ad_i;
   logic [3:0]   nb_pt_i;
   logic [63:0]  data_i;
   logic         data_valid_i;
   logic         ready_o;
   logic         busy_o;
   logic [63:0]  cipher_o;
   logic         cipher_valid_o;
   logic [127:0] tag_o;
   logic         end_o;
   logic         err_o;
`ifdef ASCON_DECRYPT_EN
   logic         decrypt_i;
   logic [127:0] tag_i;
   logic         tag_ok_o;
   logic         dec_mode;
   logic [127:0] tag_in;
   logic         got_ok;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0]  ad_blk [16];
   logic [63:0]  pt_blk [16];
   logic [63:0]  exp_ct [16];
   logic [63:0]  got_ct [16];
   int           ct_edge[16];
   int           held_edge[16];
   logic [127:0] exp_tag;
   logic [127:0] got_tag;
   int           ct_n;
   int           end_edge;
   int           ready_edge;
   bit           timed_out;
   bit           err_seen;
   logic         busy_at1;
   logic [196:0] snap;

   logic [127:0] sc_key;
   logic [127:0] sc_nonce;
   logic [63:0]  sc_ad;
   logic [63:0]  sc_pt [3];
   logic [63:0]  sc_ct [3];
   logic [127:0] sc_tag;

   ascon_aead_core #(
      .MAX_AD_BLOCKS (MAXAD),
      .MAX_PT_BLOCKS (MAXPT),
      .ROUNDS_A      (RA),
      .ROUNDS_B      (RB)
   ) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .key_i          (key_i),
      .nonce_i        (nonce_i),
      .nb_ad_i        (nb_ad_i),
      .nb_pt_i        (nb_pt_i),
      .data_i         (data_i),
      .data_valid_i   (data_valid_i),
      .ready_o        (ready_o),
      .busy_o         (busy_o),
      .cipher_o       (cipher_o),
      .cipher_valid_o (cipher_valid_o),
      .tag_o          (tag_o),
      .end_o          (end_o),
`ifdef ASCON_DECRYPT_EN
      .decrypt_i      (decrypt_i),
      .tag_i          (tag_i),
      .tag_ok_o       (tag_ok_o),
`endif
      .err_o          (err_o)
   );

   always #5 clock_i = ~clock_i;

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
      return (v >> n) | (v << (64 - n));
   endfunction

   // Reference permutation in the bitsliced form of the ASCON C implementation.
   function automatic mstate_t model_perm(input mstate_t st, input int n);
      logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
      x0 = st[0]; x1 = st[1]; x2 = st[2]; x3 = st[3]; x4 = st[4];
      for (int i = 0; i < n; i++) begin
         int j;
         j  = 12 - n + i;
         x2 = x2 ^ 64'(((15 - j) << 4) | j);
         x0 ^= x4; x4 ^= x3; x2 ^= x1;
         t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
         x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
         x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
         x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
         x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
         x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
         x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
         x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
      end
      st[0] = x0; st[1] = x1; st[2] = x2; st[3] = x3; st[4] = x4;
      return st;
   endfunction

   task automatic model_msg(input logic [127:0] key, input logic [127:0] nonce,
                            input int nad, input int npt, input bit dec);
      mstate_t st;
      st[0] = {8'h80, 8'h40, 8'(RA), 8'(RB), 32'h0};
      st[1] = key[127:64];
      st[2] = key[63:0];
      st[3] = nonce[127:64];
      st[4] = nonce[63:0];
      st = model_perm(st, RA);
      st[3] ^= key[127:64];
      st[4] ^= key[63:0];
      for (int a = 0; a < nad; a++) begin
         st[0] ^= ad_blk[a];
         st = model_perm(st, RB);
      end
      st[4] ^= 64'd1;
      for (int p = 0; p < npt; p++) begin
         exp_ct[p] = st[0] ^ pt_blk[p];
         st[0]     = dec ? pt_blk[p] : (st[0] ^ pt_blk[p]);
         if (p < npt - 1) st = model_perm(st, RB);
      end
      st[1] ^= key[127:64];
      st[2] ^= key[63:0];
      st = model_perm(st, RA);
      exp_tag = {st[3] ^ key[127:64], st[4] ^ key[63:0]};
   endtask

   // Starts a message at edge 0, feeds AD then PT blocks whenever a transfer
   // occurs, and records pulse timing and outputs. reset_at < 0 disables reset.
   task automatic run_msg(input logic [127:0] key, input logic [127:0] nonce,
                          input int nad, input int npt, input bit toggle,
                          input bit poke, input int reset_at);
      int edge_n;
      int idx;
      bit vphase;
      @(negedge clock_i);
      key_i        = key;
      nonce_i      = nonce;
      nb_ad_i      = 3'(nad);
      nb_pt_i      = 4'(npt);
      start_i      = 1'b1;
      data_valid_i = 1'b0;
      data_i       = '0;
      reset_i      = 1'b0;
`ifdef ASCON_DECRYPT_EN
      decrypt_i    = dec_mode;
      tag_i        = tag_in;
`endif
      @(posedge clock_i);
      @(negedge clock_i);
      start_i    = 1'b0;
      busy_at1   = busy_o;
      edge_n     = 0;
      idx        = 0;
      vphase     = 1'b0;
      ct_n       = 0;
      end_edge   = -1;
      ready_edge = -1;
      timed_out  = 1'b1;
      err_seen   = 1'b0;
      while (edge_n < 1000) begin
         if (ready_o && ready_edge < 0) ready_edge = edge_n;
         if (idx < nad)            data_i = ad_blk[idx];
         else if (idx < nad + npt) data_i = pt_blk[idx - nad];
         else                      data_i = '0;
         data_valid_i = toggle ? vphase : 1'b1;
         vphase = ~vphase;
         if (poke) begin
            start_i = 1'b1;
            key_i   = {r64(), r64()};
            nonce_i = {r64(), r64()};
            nb_ad_i = 3'($urandom_range(0, 7));
            nb_pt_i = 4'($urandom_range(0, 15));
         end
         if (ready_o && data_valid_i) idx++;
         reset_i = (edge_n + 1 == reset_at);
         @(posedge clock_i);
         edge_n++;
         @(negedge clock_i);
         if (err_o) err_seen = 1'b1;
         if (reset_i) begin
            reset_i   = 1'b0;
            snap      = {cipher_o, cipher_valid_o, tag_o, end_o, err_o, busy_o, ready_o};
            timed_out = 1'b0;
            break;
         end
         if (cipher_valid_o) begin
            if (ct_n < 16) begin
               got_ct[ct_n]  = cipher_o;
               ct_edge[ct_n] = edge_n;
            end
            ct_n++;
         end
         if (end_o) begin
            end_edge  = edge_n;
            got_tag   = tag_o;
`ifdef ASCON_DECRYPT_EN
            got_ok    = tag_ok_o;
`endif
            timed_out = 1'b0;
            break;
         end
      end
      start_i      = 1'b0;
      data_valid_i = 1'b0;
      reset_i      = 1'b0;
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      repeat (2) @(posedge clock_i);
      @(negedge clock_i);
      vectors++;
      if ({cipher_o, cipher_valid_o, tag_o, end_o, err_o, busy_o, ready_o} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got busy=%b ready=%b tag=%h want all zero",
                  busy_o, ready_o, tag_o);
      end
      reset_i = 1'b0;
   endtask

   task automatic test_held();
      int exp_e;
      sc_key   = {r64(), r64()};
      sc_nonce = {r64(), r64()};
      sc_ad    = r64();
      ad_blk[0] = sc_ad;
      for (int k = 0; k < 3; k++) begin
         sc_pt[k]  = r64();
         pt_blk[k] = sc_pt[k];
      end
      model_msg(sc_key, sc_nonce, 1, 3, 1'b0);
      run_msg(sc_key, sc_nonce, 1, 3, 1'b0, 1'b0, -1);
      vectors++;
      if (timed_out) begin
         miscompares++;
         $display("[TB] FAIL held_timeout: got no end_o want end_o within budget");
      end
      vectors++;
      if (busy_at1 !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL held_busy: got %b want 1", busy_at1);
      end
      vectors++;
      if (ready_edge != RA) begin
         miscompares++;
         $display("[TB] FAIL held_ready_edge: got %0d want %0d", ready_edge, RA);
      end
      vectors++;
      if (ct_n != 3) begin
         miscompares++;
         $display("[TB] FAIL held_ct_count: got %0d want 3", ct_n);
      end
      for (int k = 0; k < 3; k++) begin
         exp_e = RA + (1 + RB) + 1 + k * (1 + RB);
         held_edge[k] = exp_e;
         vectors++;
         if (ct_edge[k] != exp_e) begin
            miscompares++;
            $display("[TB] FAIL held_ct_edge[%0d]: got %0d want %0d", k, ct_edge[k], exp_e);
         end
         vectors++;
         if (got_ct[k] !== exp_ct[k]) begin
            miscompares++;
            $display("[TB] FAIL held_ct[%0d]: got %h want %h", k, got_ct[k], exp_ct[k]);
         end
         sc_ct[k] = exp_ct[k];
      end
      vectors++;
      if (end_edge != held_edge[2] + RA) begin
         miscompares++;
         $display("[TB] FAIL held_end_edge: got %0d want %0d", end_edge, held_edge[2] + RA);
      end
      vectors++;
      if (got_tag !== exp_tag) begin
         miscompares++;
         $display("[TB] FAIL held_tag: got %h want %h", got_tag, exp_tag);
      end
      sc_tag = exp_tag;
   endtask

   task automatic test_toggle();
      ad_blk[0] = sc_ad;
      for (int k = 0; k < 3; k++) pt_blk[k] = sc_pt[k];
      run_msg(sc_key, sc_nonce, 1, 3, 1'b1, 1'b0, -1);
      vectors++;
      if (timed_out || ct_n != 3) begin
         miscompares++;
         $display("[TB] FAIL toggle_count: got %0d blocks timeout=%0b want 3", ct_n, timed_out);
      end
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_ct[k] !== sc_ct[k]) begin
            miscompares++;
            $display("[TB] FAIL toggle_ct[%0d]: got %h want %h", k, got_ct[k], sc_ct[k]);
         end
         vectors++;
         if (ct_edge[k] < held_edge[k] || (k > 0 && ct_edge[k] <= ct_edge[k-1])) begin
            miscompares++;
            $display("[TB] FAIL toggle_edge[%0d]: got %0d want >= %0d and increasing",
                     k, ct_edge[k], held_edge[k]);
         end
      end
      vectors++;
      if (end_edge != ct_edge[2] + RA) begin
         miscompares++;
         $display("[TB] FAIL toggle_end_edge: got %0d want %0d", end_edge, ct_edge[2] + RA);
      end
      vectors++;
      if (got_tag !== sc_tag) begin
         miscompares++;
         $display("[TB] FAIL toggle_tag: got %h want %h", got_tag, sc_tag);
      end
   endtask

   task automatic test_midreset();
      logic [127:0] k2, n2;
      int pulses;
      ad_blk[0] = sc_ad;
      for (int k = 0; k < 3; k++) pt_blk[k] = sc_pt[k];
      run_msg(sc_key, sc_nonce, 1, 3, 1'b0, 1'b0, 30);
      vectors++;
      if (snap !== '0) begin
         miscompares++;
         $display("[TB] FAIL midreset_outputs: got %h want 0", snap);
      end
      vectors++;
      if (ct_n != 2 || end_edge != -1) begin
         miscompares++;
         $display("[TB] FAIL midreset_pulses: got ct=%0d end=%0d want ct=2 end=-1", ct_n, end_edge);
      end
      pulses = 0;
      repeat (20) begin
         @(posedge clock_i);
         @(negedge clock_i);
         if (end_o || cipher_valid_o || busy_o) pulses++;
      end
      vectors++;
      if (pulses != 0) begin
         miscompares++;
         $display("[TB] FAIL midreset_quiet: got %0d active cycles want 0", pulses);
      end
      k2 = {r64(), r64()};
      n2 = {r64(), r64()};
      ad_blk[0] = r64();
      ad_blk[1] = r64();
      pt_blk[0] = r64();
      pt_blk[1] = r64();
      model_msg(k2, n2, 2, 2, 1'b0);
      run_msg(k2, n2, 2, 2, 1'b0, 1'b0, -1);
      vectors++;
      if (timed_out || ct_n != 2 || got_ct[0] !== exp_ct[0] || got_ct[1] !== exp_ct[1]) begin
         miscompares++;
         $display("[TB] FAIL after_reset_ct: got n=%0d %h %h want %h %h",
                  ct_n, got_ct[0], got_ct[1], exp_ct[0], exp_ct[1]);
      end
      vectors++;
      if (got_tag !== exp_tag) begin
         miscompares++;
         $display("[TB] FAIL after_reset_tag: got %h want %h", got_tag, exp_tag);
      end
   endtask

   task automatic test_no_ad();
      logic [127:0] k, n;
      k = {r64(), r64()};
      n = {r64(), r64()};
      pt_blk[0] = r64();
      model_msg(k, n, 0, 1, 1'b0);
      run_msg(k, n, 0, 1, 1'b0, 1'b0, -1);
      vectors++;
      if (timed_out || ct_n != 1 || ct_edge[0] != RA + 1) begin
         miscompares++;
         $display("[TB] FAIL no_ad_ct_edge: got %0d (n=%0d) want %0d", ct_edge[0], ct_n, RA + 1);
      end
      vectors++;
      if (got_ct[0] !== exp_ct[0]) begin
         miscompares++;
         $display("[TB] FAIL no_ad_ct: got %h want %h", got_ct[0], exp_ct[0]);
      end
      vectors++;
      if (end_edge != 2 * RA + 1) begin
         miscompares++;
         $display("[TB] FAIL no_ad_end_edge: got %0d want %0d", end_edge, 2 * RA + 1);
      end
      vectors++;
      if (got_tag !== exp_tag) begin
         miscompares++;
         $display("[TB] FAIL no_ad_tag: got %h want %h", got_tag, exp_tag);
      end
   endtask

   task automatic test_errors();
      int bad_ad[3] = '{0, 5, 2};
      int bad_pt[3] = '{0, 1, 9};
      int errs;
      bit active;
      for (int c = 0; c < 3; c++) begin
         errs   = 0;
         active = 1'b0;
         @(negedge clock_i);
         nb_ad_i = 3'(bad_ad[c]);
         nb_pt_i = 4'(bad_pt[c]);
         start_i = 1'b1;
         @(posedge clock_i);
         @(negedge clock_i);
         start_i = 1'b0;
         if (err_o) errs++;
         if (busy_o || ready_o) active = 1'b1;
         repeat (4) begin
            @(posedge clock_i);
            @(negedge clock_i);
            if (err_o) errs++;
            if (busy_o || ready_o) active = 1'b1;
         end
         vectors++;
         if (errs != 1) begin
            miscompares++;
            $display("[TB] FAIL err_pulse[ad=%0d pt=%0d]: got %0d pulses want 1",
                     bad_ad[c], bad_pt[c], errs);
         end
         vectors++;
         if (active) begin
            miscompares++;
            $display("[TB] FAIL err_busy[ad=%0d pt=%0d]: got busy 1 want 0", bad_ad[c], bad_pt[c]);
         end
      end
   endtask

   task automatic test_random();
      logic [127:0] k, n;
      int nad, npt;
      bit tog, poke;
      for (int m = 0; m < 8; m++) begin
         k    = {r64(), r64()};
         n    = {r64(), r64()};
         nad  = $urandom_range(0, MAXAD);
         npt  = $urandom_range(1, MAXPT);
         tog  = 1'($urandom_range(0, 1));
         poke = 1'($urandom_range(0, 1));
         for (int a = 0; a < nad; a++) ad_blk[a] = r64();
         for (int p = 0; p < npt; p++) pt_blk[p] = r64();
         model_msg(k, n, nad, npt, 1'b0);
         run_msg(k, n, nad, npt, tog, poke, -1);
         vectors++;
         if (timed_out || ct_n != npt || err_seen) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_flow: got %0d blocks timeout=%0b err=%0b want %0d",
                     m, ct_n, timed_out, err_seen, npt);
         end
         for (int p = 0; p < npt; p++) begin
            vectors++;
            if (got_ct[p] !== exp_ct[p]) begin
               miscompares++;
               $display("[TB] FAIL rand%0d_ct[%0d]: got %h want %h", m, p, got_ct[p], exp_ct[p]);
            end
         end
         vectors++;
         if (got_tag !== exp_tag) begin
            miscompares++;
            $display("[TB] FAIL rand%0d_tag: got %h want %h", m, got_tag, exp_tag);
         end
      end
   endtask

`ifdef ASCON_DECRYPT_EN
   task automatic test_decrypt();
      logic [127:0] bad_tag;
      ad_blk[0] = sc_ad;
      for (int k = 0; k < 3; k++) pt_blk[k] = sc_ct[k];
      dec_mode = 1'b1;
      tag_in   = sc_tag;
      run_msg(sc_key, sc_nonce, 1, 3, 1'b0, 1'b0, -1);
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if (got_ct[k] !== sc_pt[k]) begin
            miscompares++;
            $display("[TB] FAIL dec_pt[%0d]: got %h want %h", k, got_ct[k], sc_pt[k]);
         end
      end
      vectors++;
      if (timed_out || got_ok !== 1'b1 || got_tag !== sc_tag) begin
         miscompares++;
         $display("[TB] FAIL dec_tag_ok: got ok=%b tag=%h want ok=1 tag=%h", got_ok, got_tag, sc_tag);
      end
      bad_tag = sc_tag;
      bad_tag[$urandom_range(0, 127)] ^= 1'b1;
      tag_in = bad_tag;
      run_msg(sc_key, sc_nonce, 1, 3, 1'b0, 1'b0, -1);
      vectors++;
      if (timed_out || got_ok !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL dec_tag_bad: got ok=%b want 0", got_ok);
      end
      dec_mode = 1'b0;
   endtask
`endif

   initial begin
      reset_i      = 1'b1;
      start_i      = 1'b0;
      key_i        = '0;
      nonce_i      = '0;
      nb_ad_i      = '0;
      nb_pt_i      = '0;
      data_i       = '0;
      data_valid_i = 1'b0;
`ifdef ASCON_DECRYPT_EN
      decrypt_i    = 1'b0;
      tag_i        = '0;
      dec_mode     = 1'b0;
      tag_in       = '0;
`endif
      test_reset();
      test_held();
      test_toggle();
      test_midreset();
      test_no_ad();
      test_errors();
      test_random();
`ifdef ASCON_DECRYPT_EN
      test_decrypt();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ascon_aead_core.md
# ascon_aead_core

Parametrised ASCON AEAD encryption core with a variable number of associated-data (AD) and plaintext (PT) blocks per message, selected at start. Rate is 64 bits; the round counts a and b are parameters. It integrates the controller, round and block counters and state datapath in one block and sits directly under the crypto top level. The optional decryption path is selected by a macro.

## Interface
- MAX_AD_BLOCKS, 4: maximum AD blocks per message.
- MAX_PT_BLOCKS, 8: maximum PT blocks per message.
- ROUNDS_A, 12: rounds used for initialisation and finalisation.
- ROUNDS_B, 6: rounds after each data block. Legal values are 6 and 8.
- clock_i  in  1  single clock; rising edge.
- reset_i  in  1  reset, synchronous, active-high.
- start_i  in  1  starts a message; accepted only in IDLE.
- key_i  in  128  key; sampled at start.
- nonce_i  in  128  nonce; sampled at start.
- nb_ad_i  in  $clog2(MAX_AD_BLOCKS+1)  AD block count; 0 is legal.
- nb_pt_i  in  $clog2(MAX_PT_BLOCKS+1)  PT block count, ≥1. The last block is already padded.
- data_i  in  64  AD or PT block.
- data_valid_i  in  1  data_i is valid. A block transfers on data_valid_i && ready_o.
- ready_o  out  1  core can absorb a block.
- busy_o  out  1  high from start acceptance until end_o.
- cipher_o  out  64  ciphertext block, registered.
- cipher_valid_o  out  1  one-cycle pulse per PT block.
- tag_o  out  128  tag. Held until the next accepted start.
- end_o  out  1  one-cycle pulse when tag_o is valid.
- err_o  out  1  one-cycle pulse when start_i is rejected.

## Operation
- The state S is x0..x4, each 64 bits.
- IV = {8'h80, 8'h40, ROUNDS_A[7:0], ROUNDS_B[7:0], 32'h0}.
- FSM states: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL.
- IDLE, start_i = 1 with legal counts:
  - S <= IV || K || N.
  - Key and counts are latched.
  - Go to INIT.
- IDLE, start_i = 1 with nb_pt_i = 0, nb_pt_i > MAX_PT_BLOCKS or nb_ad_i > MAX_AD_BLOCKS:
  - err_o pulses.
  - Stay in IDLE.
- start_i outside IDLE is ignored.
- INIT runs ROUNDS_A rounds. On the last round edge, x3 ^= K_hi and x4 ^= K_lo.
  - If nb_ad = 0, x4 ^= 1 on the same edge, then go to PT_WAIT.
  - Otherwise go to AD_WAIT.
- AD_WAIT: on transfer, x0 ^= data_i, then go to AD_PERM.
- AD_PERM runs ROUNDS_B rounds.
  - On the last round of the last AD block, x4 ^= 1, then go to PT_WAIT.
  - Otherwise go back to AD_WAIT.
- PT_WAIT, on transfer:
  - x0 <= x0 ^ data_i and cipher_o <= x0 ^ data_i.
  - cipher_valid_o pulses.
  - Non-last block: go to PT_PERM (ROUNDS_B rounds), then back to PT_WAIT.
  - Last block: on the same edge, x1 ^= K_hi and x2 ^= K_lo, then go to FINAL.
- FINAL runs ROUNDS_A rounds. On the last edge:
  - tag_o <= {x3 ^ K_hi, x4 ^ K_lo}, using the post-round state.
  - end_o pulses.
  - Go to IDLE.
- Round i of an n-round permutation uses constant c = ((15 - j) << 4) | j, where j = 12 - n + i.
- All XORs are bitwise. Counters saturate at the latched count and never wrap.

## Timing
- One round per cycle. Each absorb is one cycle.
- ready_o is high only in AD_WAIT and PT_WAIT.
- data_valid_i while ready_o = 0 is ignored; the block is not consumed.
- With start at edge 0:
  - Rounds run on edges 1..ROUNDS_A.
  - ready_o is first high after edge ROUNDS_A.
- Per data block: 1 + ROUNDS_B cycles, plus any wait while data_valid_i is low.
- Reset values:
  - All outputs are 0.
  - FSM is IDLE and S is 0.
- reset_i mid-message aborts the message. Reset values apply after the next edge; no end_o or cipher_valid_o is produced.
- start_i coinciding with reset_i is ignored.

## Configuration
- ASCON_DECRYPT_EN adds three ports:
  - decrypt_i: in, 1, sampled at start.
  - tag_i: in, 128, sampled at start.
  - tag_ok_o: out, 1, valid with end_o.
- In decrypt mode, on each PT_WAIT transfer:
  - cipher_o <= x0 ^ data_i (the recovered plaintext).
  - x0 <= data_i on non-last blocks.
  - On the last block, x0 ^= (x0 ^ data_i); padding is pre-applied by the user.
- tag_ok_o = (computed tag == tag_i). It resets to 0 and is held with tag_o.
- Without the macro:
  - The ports do not exist.
  - Encrypt only.
  - Behaviour is otherwise identical.

## Structure
- ascon_pkg contains:
  - the state_t struct (x0..x4),
  - the fsm_t enum,
  - the iv() function (from ROUNDS_A and ROUNDS_B),
  - the round-constant function.
- Sub-module ascon_round: combinational single round (constant add, 5-bit S-box, linear layer), in state_t, constant in → state_t out.

## Test plan
- nb_ad=1, nb_pt=3, data_valid_i held high, start at edge 0:
  - cipher_valid_o pulses after edges 20, 27 and 34.
  - end_o pulses after edge 46.
  - cipher_o and tag_o match the ASCON-128 C model.
- nb_ad=0, nb_pt=1:
  - end_o pulses after edge 25.
  - The tag matches the model, including domain separation on edge 12.
- nb_pt=0 → err_o pulses once; busy_o stays 0.
- nb_ad=5 with MAX_AD_BLOCKS=4 → err_o pulses once; busy_o stays 0.
- data_valid_i toggled 0/1 every cycle:
  - No block is lost or duplicated.
  - Outputs match the model.
  - The pulse sequence is the same as the held-valid run, only delayed.
- reset_i at edge 30 of the first scenario:
  - All outputs are 0 after the edge.
  - A new message started afterwards matches the model.
- ASCON_DECRYPT_EN, decrypting the output of the first scenario:
  - The plaintext is recovered.
  - tag_ok_o = 1.
  - A single flipped tag_i bit gives tag_ok_o = 0.
